// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU op classes, RISC-V funct fields, FSM states.
package exec_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_PASSB = 2'b11
  } aluop_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, XLEN cycles per product.
module exec_mul_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] product_lo_o
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mplier_q;
  logic [CW-1:0]   cnt_q;

  // done_o marks the cycle whose edge performs the last step, so the
  // product is exposed with that final partial product already added.
  always_comb begin
    acc_d        = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_o       = (cnt_q == CW'(1));
    product_lo_o = acc_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      cnt_q    <= CW'(XLEN);
    end else if (cnt_q != '0) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/exec_unit_pipe.sv
// Handshaked execute stage: register file, RV32I ALU, optional iterative MUL, output register.
module exec_unit_pipe
  import exec_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter bit          MUL_EN = 1'b1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            we,
  input  logic [1:0]      alu_op,
  input  logic            alu_src,
  input  logic [XLEN-1:0] imm,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [AW-1:0]   out_rd,
  output logic            out_we,
  output logic            illegal,
  output logic            busy
);

  localparam int unsigned SW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic [AW-1:0]   out_rd_q, out_rd_d;
  logic            valid_q, valid_d;
  logic            we_q, we_d;
  logic            illegal_q, illegal_d;

  logic            accept, wb_fire;
  logic [XLEN-1:0] op_a, op_b_reg, op_b, alu_res;
  logic [SW-1:0]   shamt;
  logic            illegal_c, is_mul;
  logic            mul_done;
  logic [XLEN-1:0] mul_prod;

  assign in_ready = (state_q == S_IDLE) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign wb_fire  = valid_q && out_ready && we_q && (out_rd_q != '0);

  // Writeback and accept share an edge, so the retiring result is forwarded.
  always_comb begin
    if (wb_fire && (rs1 == out_rd_q))  op_a = result_q;
    else if (rs1 == '0)                op_a = '0;
    else                               op_a = regs_q[rs1];
    if (wb_fire && (rs2 == out_rd_q))  op_b_reg = result_q;
    else if (rs2 == '0)                op_b_reg = '0;
    else                               op_b_reg = regs_q[rs2];
    op_b  = alu_src ? imm : op_b_reg;
    shamt = op_b[SW-1:0];
  end

  always_comb begin
    alu_res   = '0;
    illegal_c = 1'b0;
    is_mul    = 1'b0;
    case (aluop_e'(alu_op))
      ALUOP_ADD:   alu_res = op_a + op_b;
      ALUOP_SUB:   alu_res = op_a - op_b;
      ALUOP_PASSB: alu_res = op_b;
      ALUOP_FUNCT: begin
        if (funct7 == F7_MULDIV) begin
          if ((funct3 == F3_ADD) && MUL_EN) is_mul    = 1'b1;
          else                              illegal_c = 1'b1;
        end else if ((funct7 != F7_BASE) && (funct7 != F7_ALT)) begin
          illegal_c = 1'b1;
        end else begin
          case (funct3)
            F3_ADD:  alu_res = (funct7[5] && !alu_src) ? op_a - op_b : op_a + op_b;
            F3_SLL:  alu_res = op_a << shamt;
            F3_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            F3_SLTU: alu_res = XLEN'(op_a < op_b);
            F3_XOR:  alu_res = op_a ^ op_b;
            F3_SR:   alu_res = funct7[5] ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
            F3_OR:   alu_res = op_a | op_b;
            F3_AND:  alu_res = op_a & op_b;
            default: alu_res = '0;
          endcase
        end
      end
      default: alu_res = '0;
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      exec_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .start_i      (accept && is_mul),
        .a_i          (op_a),
        .b_i          (op_b),
        .done_o       (mul_done),
        .product_lo_o (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    out_rd_d  = out_rd_q;
    valid_d   = valid_q;
    we_d      = we_q;
    illegal_d = illegal_q;
    case (state_q)
      S_MUL: begin
        if (mul_done) begin
          state_d  = S_IDLE;
          result_d = mul_prod;
          valid_d  = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          rd1_d    = op_a;
          rd2_d    = op_b_reg;
          out_rd_d = rd;
          if (is_mul) begin
            state_d   = S_MUL;
            valid_d   = 1'b0;
            result_d  = '0;
            we_d      = we;
            illegal_d = 1'b0;
          end else begin
            valid_d   = 1'b1;
            result_d  = illegal_c ? '0 : alu_res;
            we_d      = we && !illegal_c;
            illegal_d = illegal_c;
          end
        end else if (out_ready) begin
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      out_rd_q  <= '0;
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      out_rd_q  <= out_rd_d;
      valid_q   <= valid_d;
      we_q      <= we_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_fire) begin
      regs_q[out_rd_q] <= result_q;
    end
  end

  assign out_valid  = valid_q;
  assign alu_result = result_q;
  assign zero       = (result_q == '0);
  assign rd1        = rd1_q;
  assign rd2        = rd2_q;
  assign out_rd     = out_rd_q;
  assign out_we     = we_q;
  assign illegal    = illegal_q;
  assign busy       = (state_q == S_MUL);

endmodule
